// File: rtl/frodo_codec.sv
// frodo_codec: streaming FrodoKEM level encoder/decoder with per-frame config latch,
// one registered output stage and frame-end marking.
module frodo_codec #(
    parameter int LANES       = 4,
    parameter int FRAME_BEATS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [1:0]            level,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   out_data,
    output logic                  out_last,
    output logic                  busy
);
    localparam int CW = FRAME_BEATS > 1 ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_BEATS - 1);

    // Sum is 17 bits so that c' + 2^(S-1) near 2^16 wraps away cleanly under mod 2^B.
    function automatic logic [15:0] lane_op(input logic m, input logic [1:0] lv, input logic [15:0] x);
        logic [3:0]  s;
        logic [15:0] dmask, bmask;
        logic [16:0] sum;
        s     = (lv == 2'b01) ? 4'd12 : 4'd13;
        dmask = (lv == 2'b11) ? 16'h7fff : 16'hffff;
        bmask = (lv == 2'b01) ? 16'h000f : (lv == 2'b10) ? 16'h0007 : 16'h0003;
        sum   = {1'b0, x & dmask} + (17'd1 << (s - 4'd1));
        return m ? (16'(sum >> s) & bmask) : (((x & bmask) << s) & dmask);
    endfunction

    logic [CW-1:0]         cnt;
    logic                  cfg_en, cfg_mode;
    logic [1:0]            cfg_level;
    logic                  accept, first, eff_en, eff_mode;
    logic [1:0]            eff_level;
    logic [16*LANES-1:0]   proc;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign first    = cnt == '0;
    assign busy     = !first;

    // The first beat of a frame uses the live config; the rest use the latched copy.
    always_comb begin
        eff_en    = first ? en : cfg_en;
        eff_mode  = first ? mode : cfg_mode;
        eff_level = first ? level : cfg_level;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign proc[16*i +: 16] = (eff_en && eff_level != 2'b00)
            ? lane_op(eff_mode, eff_level, in_data[16*i +: 16]) : in_data[16*i +: 16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cfg_en    <= 1'b0;
            cfg_mode  <= 1'b0;
            cfg_level <= 2'b00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_data  <= proc;
            out_last  <= cnt == LAST;
            out_valid <= 1'b1;
            cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
            if (first) begin
                cfg_en    <= en;
                cfg_mode  <= mode;
                cfg_level <= level;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_frodo_codec.sv
// tb_frodo_codec: directed and randomized checks of frodo_codec against an arithmetic reference model.
module tb_frodo_codec;
    localparam int LANES = 4;
    localparam int FB    = 16;
    localparam int W     = 16 * LANES;

    logic clk = 1'b0;
    logic rst, en, mode, in_valid, out_ready, in_ready, out_valid, out_last, busy;
    logic [1:0]   level;
    logic [W-1:0] in_data, out_data;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    logic         m_valid, m_last, c_en, c_mode;
    logic [1:0]   c_level;
    logic [W-1:0] m_data;
    int           m_cnt;

    frodo_codec #(.LANES(LANES), .FRAME_BEATS(FB)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .level(level),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int bits_b(input logic [1:0] lv);
        return lv == 2'd1 ? 4 : lv == 2'd2 ? 3 : 2;
    endfunction

    function automatic logic [15:0] ref_lane(input logic e, input logic md, input logic [1:0] lv, input logic [15:0] x);
        int b, d, s, v;
        if (!e || lv == 2'd0) return x;
        b = bits_b(lv);
        d = lv == 2'd3 ? 15 : 16;
        s = d - b;
        v = md ? ((((int'(x) % (1 << d)) + (1 << (s - 1))) / (1 << s)) % (1 << b))
               : (((int'(x) % (1 << b)) * (1 << s)) % (1 << d));
        return 16'(v);
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic e, input logic md, input logic [1:0] lv, input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int l = 0; l < LANES; l++) r[16*l +: 16] = ref_lane(e, md, lv, x[16*l +: 16]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: compare against the model, then advance the model with the pre-edge inputs.
    task automatic tick();
        logic acc, e, md;
        logic [1:0] lv;
        #2;
        if (chk_on) begin
            chk("in_ready", W'(in_ready), W'(!m_valid || out_ready));
            chk("out_valid", W'(out_valid), W'(m_valid));
            chk("out_data", out_data, m_data);
            chk("out_last", W'(out_last), W'(m_last));
            chk("busy", W'(busy), W'(m_cnt != 0));
        end
        acc = in_valid && (!m_valid || out_ready);
        e   = m_cnt == 0 ? en : c_en;
        md  = m_cnt == 0 ? mode : c_mode;
        lv  = m_cnt == 0 ? level : c_level;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_last = 0; m_data = '0; m_cnt = 0;
            c_en = 0; c_mode = 0; c_level = 2'd0;
        end else if (acc) begin
            if (m_cnt == 0) begin c_en = en; c_mode = mode; c_level = level; end
            m_data  = ref_beat(e, md, lv, in_data);
            m_last  = m_cnt == FB - 1;
            m_valid = 1;
            m_cnt   = (m_cnt + 1) % FB;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; out_ready = 1;
        tick();
        rst = 0;
    endtask

    task automatic beat(input logic e, input logic md, input logic [1:0] lv, input logic [W-1:0] d);
        en = e; mode = md; level = lv; in_data = d; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [W-1:0] msg, enc, exp, d;
        rst = 1; en = 0; mode = 0; level = 0; in_valid = 0; out_ready = 1; in_data = '0;
        do_reset();
        chk_on = 1;
        tick();
        chk("reset_valid", W'(out_valid), '0);
        chk("reset_busy", W'(busy), '0);
        chk("reset_ready", W'(in_ready), W'(1));
        chk("reset_data", out_data, '0);

        beat(1, 0, 2'd1, {16'hFFF1, 16'h0000, 16'h000F, 16'h0005});
        chk("enc01", out_data, {16'h1000, 16'h0000, 16'hF000, 16'h5000});
        do_reset();
        beat(1, 0, 2'd2, {48'h0, 16'h0005});
        chk("enc10", out_data, {48'h0, 16'hA000});
        do_reset();
        beat(1, 0, 2'd3, {48'h0, 16'h0007});
        chk("enc11", out_data, {48'h0, 16'h6000});
        do_reset();
        beat(1, 1, 2'd3, {16'h0000, 16'hB000, 16'h7000, 16'h3000});
        chk("dec11", out_data, {16'h0000, 16'h0002, 16'h0000, 16'h0002});
        do_reset();
        beat(1, 1, 2'd1, {16'h0000, 16'h0000, 16'hF900, 16'h0800});
        chk("dec01", out_data, {16'h0000, 16'h0000, 16'h0000, 16'h0001});
        do_reset();
        beat(1, 1, 2'd2, {48'h0, 16'h1000});
        chk("dec10", out_data, {48'h0, 16'h0001});

        for (int lv = 1; lv <= 3; lv++) begin
            for (int t = 0; t < 3; t++) begin
                msg = rnd();
                do_reset();
                beat(1, 0, 2'(lv), msg);
                enc = out_data;
                do_reset();
                beat(1, 1, 2'(lv), enc);
                for (int l = 0; l < LANES; l++)
                    exp[16*l +: 16] = 16'(int'(msg[16*l +: 16]) % (1 << bits_b(2'(lv))));
                chk("roundtrip", out_data, exp);
            end
        end

        for (int t = 0; t < 4; t++) begin
            d = rnd();
            do_reset();
            beat(0, 1'(t), 2'(1 + t % 3), d);
            chk("pass_en0", out_data, d);
            do_reset();
            beat(1, 1'(t), 2'd0, d);
            chk("pass_lvl0", out_data, d);
        end

        do_reset();
        for (int j = 0; j < 2 * FB; j++) begin
            beat(1, 0, 2'd1, rnd());
            chk("frame_last", W'(out_last), W'(j == FB - 1 || j == 2 * FB - 1));
            if (j == FB - 1 || j == 2 * FB - 1) chk("frame_busy", W'(busy), '0);
        end

        do_reset();
        for (int j = 0; j <= FB; j++) begin
            d = rnd();
            beat(1, 0, j < 3 ? 2'd1 : 2'd3, d);
            chk("midframe", out_data, ref_beat(1, 0, j < FB ? 2'd1 : 2'd3, d));
        end

        do_reset();
        for (int c = 0; c < 400; c++) begin
            en = 1'($urandom); mode = 1'($urandom); level = 2'($urandom);
            in_data = rnd();
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            tick();
        end

        do_reset();
        for (int j = 0; j < 7; j++) beat(1, 1, 2'd2, rnd());
        rst = 1; in_valid = 1; in_data = rnd();
        tick();
        rst = 0; in_valid = 0;
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_busy", W'(busy), '0);
        for (int j = 0; j < FB; j++) begin
            beat(1, 0, 2'd3, rnd());
            chk("rst_last", W'(out_last), W'(j == FB - 1));
        end
        out_ready = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
